// File: rtl/registers.sv
// rtl/registers.sv - dual-read, single-write general-purpose register file
//
// Purpose:
//   Holds 2**ADDR_WIDTH registers of DATA_WIDTH bits each. Every register is
//   general purpose, so register 0 is writable. There is one synchronous
//   write port and two independent asynchronous read ports.
//
// Ports:
//   Rdst        in   DATA_WIDTH  write data
//   Rsrc1       out  DATA_WIDTH  read data, port 1 (combinational)
//   Rsrc2       out  DATA_WIDTH  read data, port 2 (combinational)
//   Rdst_addr   in   ADDR_WIDTH  write address
//   Rsrc1_addr  in   ADDR_WIDTH  read address, port 1
//   Rsrc2_addr  in   ADDR_WIDTH  read address, port 2
//   clk         in   1           clock; all state changes on its rising edge
//   Rwrite      in   1           write enable, active-high
//   rst         in   1           synchronous active-high clear of all registers
module registers #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] Rdst,
  output logic [DATA_WIDTH-1:0] Rsrc1,
  output logic [DATA_WIDTH-1:0] Rsrc2,
  input  logic [ADDR_WIDTH-1:0] Rdst_addr,
  input  logic [ADDR_WIDTH-1:0] Rsrc1_addr,
  input  logic [ADDR_WIDTH-1:0] Rsrc2_addr,
  input  logic                  clk,
  input  logic                  Rwrite,
  input  logic                  rst
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (Rwrite) begin
      regs_d[Rdst_addr] = Rdst;
    end
  end

  // Reset is checked first, so a write in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // The reads come from the stored array only. A write in flight is not
  // forwarded, so a read sees the old value until the clock edge.
  assign Rsrc1 = regs_q[Rsrc1_addr];
  assign Rsrc2 = regs_q[Rsrc2_addr];

endmodule

// File: tb/tb_registers.sv
// tb/tb_registers.sv - self-checking bench for the registers block
module tb_registers;

  logic [15:0] Rdst;
  logic [15:0] Rsrc1;
  logic [15:0] Rsrc2;
  logic [4:0]  Rdst_addr;
  logic [4:0]  Rsrc1_addr;
  logic [4:0]  Rsrc2_addr;
  logic        clk;
  logic        Rwrite;
  logic        rst;

  int checks = 0;
  int errors = 0;

  // Expected contents of the register file.
  logic [15:0] model [32];

  registers #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
    .Rdst       (Rdst),
    .Rsrc1      (Rsrc1),
    .Rsrc2      (Rsrc2),
    .Rdst_addr  (Rdst_addr),
    .Rsrc1_addr (Rsrc1_addr),
    .Rsrc2_addr (Rsrc2_addr),
    .clk        (clk),
    .Rwrite     (Rwrite),
    .rst        (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 16'h0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [15:0] d);
    Rwrite = 1'b1; Rdst_addr = a; Rdst = d;
    tick();
    Rwrite = 1'b0;
    model[a] = d;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) write_reg(5'(i * 5), 16'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    Rsrc1_addr = 5'd0; Rsrc2_addr = 5'd31;
    #1;
    checks++;
    if (Rsrc1 !== 16'h0 || Rsrc2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_r0_r31: got %h/%h required 0000/0000", Rsrc1, Rsrc2);
    end
    for (int i = 0; i < 32; i++) begin
      Rsrc1_addr = 5'(i); Rsrc2_addr = 5'(31 - i);
      #1;
      checks++;
      if (Rsrc1 !== 16'h0 || Rsrc2 !== 16'h0) begin
        errors++;
        $display("FAIL reset_all addr %0d: got %h/%h required 0000/0000", i, Rsrc1, Rsrc2);
      end
    end
  endtask

  task automatic test_write_read();
    // Two writes on consecutive edges with Rwrite held high.
    Rwrite = 1'b1; Rdst_addr = 5'd1; Rdst = 16'd47;
    tick();
    model[1] = 16'd47;
    Rdst_addr = 5'd2; Rdst = 16'd74;
    tick();
    model[2] = 16'd74;
    Rwrite = 1'b0;
    Rsrc1_addr = 5'd1; Rsrc2_addr = 5'd2;
    #1;
    checks++;
    if (Rsrc1 !== 16'd47 || Rsrc2 !== 16'd74) begin
      errors++;
      $display("FAIL write_read: got %0d/%0d required 47/74", Rsrc1, Rsrc2);
    end
  endtask

  task automatic test_no_write();
    Rwrite = 1'b0; Rdst_addr = 5'd3; Rdst = 16'hFFFF;
    repeat (3) tick();
    Rsrc1_addr = 5'd3; Rsrc2_addr = 5'd3;
    #1;
    checks++;
    if (Rsrc1 !== 16'h0 || Rsrc2 !== model[3]) begin
      errors++;
      $display("FAIL no_write_r3: got %h/%h required 0000/%h", Rsrc1, Rsrc2, model[3]);
    end
  endtask

  task automatic test_same_addr();
    Rsrc1_addr = 5'd1; Rsrc2_addr = 5'd1;
    #1;
    checks++;
    if (Rsrc1 !== 16'd47 || Rsrc2 !== 16'd47) begin
      errors++;
      $display("FAIL same_addr_initial: got %0d/%0d required 47/47", Rsrc1, Rsrc2);
    end
    Rwrite = 1'b1; Rdst_addr = 5'd1; Rdst = 16'd100;
    #2;
    checks++;
    if (Rsrc1 !== 16'd47 || Rsrc2 !== 16'd47) begin
      errors++;
      $display("FAIL same_addr_before_edge: got %0d/%0d required 47/47", Rsrc1, Rsrc2);
    end
    tick();
    Rwrite = 1'b0;
    model[1] = 16'd100;
    checks++;
    if (Rsrc1 !== 16'd100 || Rsrc2 !== 16'd100) begin
      errors++;
      $display("FAIL same_addr_after_edge: got %0d/%0d required 100/100", Rsrc1, Rsrc2);
    end
  endtask

  task automatic test_reset_priority();
    write_reg(5'd5, 16'h1234);
    Rsrc1_addr = 5'd5; Rsrc2_addr = 5'd1;
    #1;
    checks++;
    if (Rsrc1 !== 16'h1234) begin
      errors++;
      $display("FAIL prio_setup_r5: got %h required 1234", Rsrc1);
    end
    rst = 1'b1; Rwrite = 1'b1; Rdst_addr = 5'd5; Rdst = 16'hABCD;
    tick();
    rst = 1'b0; Rwrite = 1'b0;
    model_clear();
    checks++;
    if (Rsrc1 !== 16'h0 || Rsrc2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_priority: got %h/%h required 0000/0000", Rsrc1, Rsrc2);
    end
  endtask

  task automatic test_boundary();
    write_reg(5'd0, 16'hFFFF);
    write_reg(5'd31, 16'h8000);
    Rsrc1_addr = 5'd0; Rsrc2_addr = 5'd31;
    #1;
    checks++;
    if (Rsrc1 !== 16'hFFFF || Rsrc2 !== 16'h8000) begin
      errors++;
      $display("FAIL boundary_r0_r31: got %h/%h required FFFF/8000", Rsrc1, Rsrc2);
    end
  endtask

  task automatic test_between_edges();
    write_reg(5'd7, 16'h5A5A);
    Rsrc1_addr = 5'd7; Rsrc2_addr = 5'd0;
    // Write controls pulse high mid-cycle but are low at the edge.
    Rwrite = 1'b1; Rdst_addr = 5'd7; Rdst = 16'h0F0F;
    #2;
    Rwrite = 1'b0; Rdst = 16'h1111;
    tick();
    checks++;
    if (Rsrc1 !== 16'h5A5A) begin
      errors++;
      $display("FAIL glitch_write: got %h required 5a5a", Rsrc1);
    end
    // Reset pulsed between edges must not clear anything.
    rst = 1'b1;
    #2;
    checks++;
    if (Rsrc1 !== 16'h5A5A || Rsrc2 !== model[0]) begin
      errors++;
      $display("FAIL rst_midcycle: got %h/%h required 5a5a/%h", Rsrc1, Rsrc2, model[0]);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (Rsrc1 !== 16'h5A5A || Rsrc2 !== model[0]) begin
      errors++;
      $display("FAIL rst_glitch_edge: got %h/%h required 5a5a/%h", Rsrc1, Rsrc2, model[0]);
    end
  endtask

  task automatic test_random();
    logic       w, r;
    logic [4:0] wa;
    logic [15:0] wd;
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 49) == 0);
      wa = 5'($urandom);
      wd = 16'($urandom);
      Rwrite = w; rst = r; Rdst_addr = wa; Rdst = wd;
      Rsrc1_addr = 5'($urandom);
      Rsrc2_addr = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      #1;
      checks++;
      if (Rsrc1 !== model[Rsrc1_addr] || Rsrc2 !== model[Rsrc2_addr]) begin
        errors++;
        $display("FAIL random cycle %0d addr %0d/%0d: got %h/%h required %h/%h",
                 n, Rsrc1_addr, Rsrc2_addr, Rsrc1, Rsrc2,
                 model[Rsrc1_addr], model[Rsrc2_addr]);
      end
      tick();
      if (r) model_clear();
      else if (w) model[wa] = wd;
    end
    Rwrite = 1'b0; rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Rsrc1_addr = 5'(i); Rsrc2_addr = 5'(i ^ 5'h1F);
      #1;
      checks++;
      if (Rsrc1 !== model[i] || Rsrc2 !== model[i ^ 31]) begin
        errors++;
        $display("FAIL random_final addr %0d: got %h/%h required %h/%h",
                 i, Rsrc1, Rsrc2, model[i], model[i ^ 31]);
      end
    end
  endtask

  initial begin
    Rdst = '0; Rdst_addr = '0; Rsrc1_addr = '0; Rsrc2_addr = '0;
    Rwrite = 1'b0; rst = 1'b1;
    model_clear();
    tick();
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_no_write();
    test_same_addr();
    test_reset_priority();
    test_boundary();
    test_between_edges();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/registers.md
REGISTERS -- requirements
Module: registers

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 16, the register word width in bits.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 5, the address width; depth is 2**ADDR_WIDTH (32 registers).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port Rdst  input  DATA_WIDTH  write data.
REQ-006 Port Rsrc1  output  DATA_WIDTH  read data, port 1.
REQ-007 Port Rsrc2  output  DATA_WIDTH  read data, port 2.
REQ-008 Port Rdst_addr  input  ADDR_WIDTH  write address.
REQ-009 Port Rsrc1_addr  input  ADDR_WIDTH  read address, port 1.
REQ-010 Port Rsrc2_addr  input  ADDR_WIDTH  read address, port 2.
REQ-011 Port Rwrite  input  1  write enable, active-high.
REQ-012 Positional port order SHALL be Rdst, Rsrc1, Rsrc2, Rdst_addr, Rsrc1_addr, Rsrc2_addr, clk, Rwrite, rst.

Function
REQ-013 The block SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits, all general-purpose (register 0 is writable, not hardwired).
REQ-014 On a rising clk edge with rst=0 and Rwrite=1, register[Rdst_addr] SHALL take Rdst; all other registers hold.
REQ-015 On a rising clk edge with rst=0 and Rwrite=0, no register SHALL change.
REQ-016 Rsrc1 SHALL equal register[Rsrc1_addr] combinationally (zero-cycle latency, follows address changes without a clock edge).
REQ-017 Rsrc2 SHALL equal register[Rsrc2_addr] combinationally, independent of port 1.
REQ-018 Both read ports SHALL be allowed to address the same register simultaneously and return identical data.
REQ-019 Read of the register being written in the same cycle SHALL return the old contents until the rising edge, then the new contents (no write-to-read bypass).
REQ-020 Changes of Rdst, Rdst_addr or Rwrite between edges SHALL have no effect on stored state; only values sampled at the rising edge matter.
REQ-021 Write data SHALL be stored unmodified, full DATA_WIDTH, no sign or width conversion.

Reset
REQ-022 On a rising clk edge with rst=1, every register SHALL be cleared to 0, regardless of Rwrite.
REQ-023 rst SHALL take priority over a simultaneous write; the write is discarded.
REQ-024 After reset, Rsrc1 and Rsrc2 SHALL read 0 for any address.
REQ-025 Asserting rst between edges SHALL not alter state until the next rising edge.

Verification
REQ-026 Reset 1 cycle, then Rsrc1_addr=0, Rsrc2_addr=31 -> Rsrc1=0, Rsrc2=0.
REQ-027 Rwrite=1: write 47 to R1 at edge n, 74 to R2 at edge n+1; Rwrite=0; Rsrc1_addr=1, Rsrc2_addr=2 -> Rsrc1=47, Rsrc2=74 with no further clock edge needed after address change.
REQ-028 Rwrite=0, Rdst_addr=3, Rdst=16'hFFFF, clock 3 edges -> R3 reads 0.
REQ-029 Rsrc1_addr=Rsrc2_addr=1 with R1=47 -> both outputs 47; write 100 to R1 -> both show 47 before the edge, 100 after.
REQ-030 R5=16'h1234, then rst=1 and Rwrite=1 with Rdst_addr=5, Rdst=16'hABCD at same edge -> R5 reads 0.
REQ-031 Write 16'hFFFF to R0 and 16'h8000 to R31 -> read back 16'hFFFF and 16'h8000 exactly.
